// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: shared constants and bit helpers for the queued priority encoder
package prio_enc_pkg;
    localparam int DEFAULT_N = 4;
    localparam int MAX_N = 64;

    function automatic int popcount(input logic [MAX_N-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < MAX_N; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic logic [MAX_N-1:0] onehot(input int k);
        return MAX_N'(1) << k;
    endfunction
endpackage

// File: rtl/prio_encoder_q_sel.sv
// prio_sel: combinational selector, first set bit searching downward from start with wrap
module prio_sel
    import prio_enc_pkg::*;
#(
    parameter int N = DEFAULT_N,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] p,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         any
);
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && p[(int'(start) + N - i) % N]) begin
                idx = W'((int'(start) + N - i) % N);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/prio_encoder_q.sv
// prio_encoder_q: registered priority encoder with pending-request queue and valid/ready output
// Define PRIO_ENC_ROUND_ROBIN_EN for rotating priority; default is fixed (line N-1 highest).
module prio_encoder_q
    import prio_enc_pkg::*;
#(
    parameter int N = DEFAULT_N,
    localparam int W = $clog2(N),
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    output logic [W-1:0]  idx_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [CW-1:0] pend_cnt_o,
    output logic          merge_o
);
    logic [N-1:0] p;
    logic [N-1:0] grant;
    logic [W-1:0] start;
    logic [W-1:0] sel_idx;
    logic         sel_any;
    logic         load;

    prio_sel #(.N(N)) u_sel (
        .p     (p),
        .start (start),
        .idx   (sel_idx),
        .any   (sel_any)
    );

`ifdef PRIO_ENC_ROUND_ROBIN_EN
    logic [W-1:0] ptr;
    assign start = ptr;
    // Next search starts just below the line just granted, so every pending line is reached within N grants.
    always_ff @(posedge clk) begin
        if (rst) ptr <= W'(N - 1);
        else if (load && sel_any) ptr <= (sel_idx == '0) ? W'(N - 1) : sel_idx - 1'b1;
    end
`else
    assign start = W'(N - 1);
`endif

    assign load       = !valid_o || ready_i;
    assign grant      = (load && sel_any) ? N'(onehot(int'(sel_idx))) : '0;
    assign pend_cnt_o = CW'(popcount(MAX_N'(p)));

    // Set wins over clear, so a request on the line being granted stays pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            p       <= '0;
            valid_o <= 1'b0;
            idx_o   <= '0;
            merge_o <= 1'b0;
        end else begin
            p       <= (p & ~grant) | req_i;
            merge_o <= |(req_i & p & ~grant);
            if (load) begin
                valid_o <= sel_any;
                if (sel_any) idx_o <= sel_idx;
            end
        end
    end
endmodule
